// File: rtl/dec_iq_pkg.sv
// Shared defaults and helpers for the decode-to-execute issue queue.
package dec_iq_pkg;

  localparam int PAYLOAD_W_DEF = 128;
  localparam int ADDR_W_DEF    = 5;
  localparam int DEPTH_DEF     = 4;
  localparam int CNT_W_DEF     = 32;

  localparam logic [ADDR_W_DEF-1:0] ZERO_REG = '0;

  // Occupancy needs one extra bit so that a full queue is distinguishable from empty.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dec_issue_queue_sat_cnt.sv
// Saturating up-counter used for stall profiling; cleared only by reset.
module sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dec_issue_queue.sv
// FIFO of decoded bundles between decoder and EXU, gated by the write-in-flight
// scoreboard, with single-cycle flush and saturating stall counters.
module dec_issue_queue
  import dec_iq_pkg::*;
#(
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PAYLOAD_W-1:0]  in_payload,
  input  logic [ADDR_W-1:0]     in_rd,
  input  logic                  in_regwr,
  input  logic                  raw_hazard,
  input  logic                  sb_full,
  input  logic                  flush,
  output logic                  disp_en,
  output logic [ADDR_W-1:0]     disp_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PAYLOAD_W-1:0]  out_payload,
  output logic [$clog2(DEPTH):0] count,
  output logic [CNT_W-1:0]      stall_raw_cnt,
  output logic [CNT_W-1:0]      stall_full_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PAYLOAD_W-1:0] mem_q [DEPTH];
  logic [PAYLOAD_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 full, push, pop;

  assign full      = (count_q == FULL_CNT);
  assign out_valid = (count_q != '0) && !flush;
  assign pop       = out_valid && out_ready;
  // A full queue still accepts when the head leaves in the same cycle.
  assign in_ready  = (!full || pop) && !raw_hazard && !sb_full && !flush && !rst;
  assign push      = in_valid && in_ready;

  assign out_payload = mem_q[rd_ptr_q];
  assign disp_en     = push && in_regwr && (in_rd != ADDR_W'(ZERO_REG));
  assign disp_rd     = in_rd;
  assign count       = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_payload;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  sat_cnt #(.CNT_W(CNT_W)) u_stall_raw (
    .clk (clk),
    .rst (rst),
    .en  (in_valid && raw_hazard),
    .cnt (stall_raw_cnt)
  );

  sat_cnt #(.CNT_W(CNT_W)) u_stall_full (
    .clk (clk),
    .rst (rst),
    .en  (in_valid && full && !pop && !flush),
    .cnt (stall_full_cnt)
  );

endmodule

// File: tb/tb_dec_issue_queue.sv
// Scoreboard bench for dec_issue_queue: driver queues expected bundles, monitor checks pops.
module tb_dec_issue_queue;

  localparam int PW = 128;
  localparam int AW = 5;
  localparam int D  = 4;
  localparam int CW = 32;

  logic          clk = 0;
  logic          rst = 1;
  logic          in_valid = 0, in_ready, in_regwr = 0;
  logic [PW-1:0] in_payload = '0;
  logic [AW-1:0] in_rd = '0;
  logic          raw_hazard = 0, sb_full = 0, flush = 0;
  logic          disp_en;
  logic [AW-1:0] disp_rd;
  logic          out_valid, out_ready = 0;
  logic [PW-1:0] out_payload;
  logic [$clog2(D):0] count;
  logic [CW-1:0] stall_raw_cnt, stall_full_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [PW-1:0] exp_q [$];

  dec_issue_queue #(.PAYLOAD_W(PW), .ADDR_W(AW), .DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_payload(in_payload), .in_rd(in_rd), .in_regwr(in_regwr),
    .raw_hazard(raw_hazard), .sb_full(sb_full), .flush(flush),
    .disp_en(disp_en), .disp_rd(disp_rd), .out_valid(out_valid),
    .out_ready(out_ready), .out_payload(out_payload), .count(count),
    .stall_raw_cnt(stall_raw_cnt), .stall_full_cnt(stall_full_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Monitor: every DUT pop is checked against the oldest expected bundle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pop_unexpected act=%0h exp=none", out_payload);
        end else begin
          chk("out_payload", out_payload, exp_q.pop_front());
        end
      end
    end
  end

  // One cycle of stimulus; entered and left at posedge+1.
  task automatic cyc(input logic v, input logic [PW-1:0] p, input logic [AW-1:0] rd,
                     input logic wr, input logic haz, input logic sbf, input logic fl,
                     input logic ordy, input logic exp_ov, input logic exp_rdy,
                     input logic exp_disp);
    in_valid = v; in_payload = p; in_rd = rd; in_regwr = wr;
    raw_hazard = haz; sb_full = sbf; flush = fl; out_ready = ordy;
    @(negedge clk);
    #1;
    chk("out_valid", {127'd0, out_valid}, {127'd0, exp_ov});
    chk("in_ready", {127'd0, in_ready}, {127'd0, exp_rdy});
    chk("disp_en", {127'd0, disp_en}, {127'd0, exp_disp});
    if (exp_disp) chk("disp_rd", {123'd0, disp_rd}, {123'd0, rd});
    if (v && exp_rdy) exp_q.push_back(p);
    if (fl) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    #1;
    chk("rst_count", {125'd0, count}, 128'd0);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
    chk("rst_out_payload", out_payload, 128'd0);
    chk("rst_stall_raw", {96'd0, stall_raw_cnt}, 128'd0);
    chk("rst_stall_full", {96'd0, stall_full_cnt}, 128'd0);
    rst = 0;
    @(posedge clk);
    #1;

    // Fill to DEPTH with EXU stalled
    cyc(1, 128'h1, 5'd1, 1, 0, 0, 0, 0, 0, 1, 1);
    cyc(1, 128'h2, 5'd2, 1, 0, 0, 0, 0, 1, 1, 1);
    cyc(1, 128'h3, 5'd3, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(1, 128'h4, 5'd4, 1, 0, 0, 0, 0, 1, 1, 1);
    chk("fill_count", {125'd0, count}, 128'd4);
    cyc(1, 128'h5, 5'd5, 1, 0, 0, 0, 0, 1, 0, 0);
    chk("stall_full_1", {96'd0, stall_full_cnt}, 128'd1);
    cyc(1, 128'h5, 5'd5, 1, 0, 0, 0, 0, 1, 0, 0);
    chk("stall_full_2", {96'd0, stall_full_cnt}, 128'd2);
    chk("full_count", {125'd0, count}, 128'd4);

    // Concurrent push/pop at full, wrapping pointers
    for (int i = 5; i <= 8; i++) begin
      cyc(1, PW'(i), 5'd0, 0, 0, 0, 0, 1, 1, 1, 0);
      chk("steady_count", {125'd0, count}, 128'd4);
    end
    chk("stall_full_hold", {96'd0, stall_full_cnt}, 128'd2);
    for (int i = 0; i < 4; i++) cyc(0, '0, 5'd0, 0, 0, 0, 0, 1, 1, 1, 0);
    chk("drain_count", {125'd0, count}, 128'd0);
    chk("drain_sb_empty", 128'(exp_q.size()), 128'd0);

    // RAW hazard gating
    for (int i = 0; i < 3; i++) cyc(1, 128'h9, 5'd3, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("stall_raw_3", {96'd0, stall_raw_cnt}, 128'd3);
    chk("raw_count", {125'd0, count}, 128'd0);

    // Dispatch qualification and scoreboard-full gating
    cyc(1, 128'hA, 5'd7, 1, 0, 0, 0, 0, 0, 1, 1);
    cyc(1, 128'hB, 5'd0, 1, 0, 0, 0, 0, 1, 1, 0);
    cyc(1, 128'hC, 5'd5, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(1, 128'hD, 5'd4, 1, 0, 1, 0, 0, 1, 0, 0);
    chk("disp_count", {125'd0, count}, 128'd3);

    // Flush with a concurrent push attempt
    cyc(1, 128'hE, 5'd6, 1, 0, 0, 1, 1, 0, 0, 0);
    chk("flush_count", {125'd0, count}, 128'd0);
    chk("flush_out_valid", {127'd0, out_valid}, 128'd0);
    chk("flush_stall_full", {96'd0, stall_full_cnt}, 128'd2);

    // Async reset between edges
    cyc(1, 128'h11, 5'd1, 1, 0, 0, 0, 0, 0, 1, 1);
    cyc(1, 128'h12, 5'd0, 1, 0, 0, 0, 0, 1, 1, 0);
    in_valid = 0;
    chk("pre_rst_count", {125'd0, count}, 128'd2);
    #2 rst = 1;
    #1;
    chk("arst_count", {125'd0, count}, 128'd0);
    chk("arst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("arst_out_payload", out_payload, 128'd0);
    chk("arst_stall_raw", {96'd0, stall_raw_cnt}, 128'd0);
    chk("arst_stall_full", {96'd0, stall_full_cnt}, 128'd0);
    chk("arst_in_ready", {127'd0, in_ready}, 128'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;

    // Post-reset push then pop
    cyc(1, 128'h21, 5'd2, 1, 0, 0, 0, 1, 0, 1, 1);
    cyc(0, '0, 5'd0, 0, 0, 0, 0, 1, 1, 1, 0);
    chk("final_count", {125'd0, count}, 128'd0);
    chk("final_sb_empty", 128'(exp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
